// File: rtl/udcnt_mod.sv
// udcnt_mod: parametrised up/down modulo counter with programmable step,
// synchronous clear/load, wrap or saturate boundary mode, a registered wrap
// pulse and a combinational terminal count for cascading.
module udcnt_mod #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 200,
    parameter bit SAT     = 1'b0
) (
    input  logic             clk,
    input  logic             rstx,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             ena,
    input  logic             upx,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             tc,
    output logic             sat,
    output logic             lderr
);

    // Boundary compares use the full WIDTH+1-bit modulus so that
    // MODULUS = 2^WIDTH is handled. Wrapped results are always below MODULUS,
    // so computing them modulo 2^WIDTH with the low modulus bits is exact.
    localparam logic [WIDTH:0]   C_MOD_W  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] C_MOD_LO = WIDTH'(MODULUS);
    localparam logic [WIDTH-1:0] C_MAX    = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_sat;
    logic             r_lderr;

    logic [WIDTH:0]   w_sum;
    logic             w_up_over;
    logic             w_dn_under;
    logic             w_step_nz;
    logic             w_ld_ok;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;
    logic             w_sat_nxt;
    logic             w_lderr_nxt;

    assign w_sum      = {1'b0, r_q} + {1'b0, step};
    assign w_up_over  = (w_sum >= C_MOD_W);
    assign w_dn_under = (r_q < step);
    assign w_step_nz  = |step;
    assign w_ld_ok    = ({1'b0, ld_val} < C_MOD_W);

    // Next-state selection: clr > load > ena > hold.
    always_comb begin
        w_q_nxt     = r_q;
        w_wrap_nxt  = 1'b0;
        w_sat_nxt   = r_sat;
        w_lderr_nxt = 1'b0;
        if (clr) begin
            w_q_nxt   = '0;
            w_sat_nxt = 1'b0;
        end else if (load) begin
            if (w_ld_ok) begin
                w_q_nxt = ld_val;
            end else begin
                w_lderr_nxt = 1'b1;
            end
        end else if (ena) begin
            if (!upx) begin
                if (!w_up_over) begin
                    w_q_nxt = w_sum[WIDTH-1:0];
                end else if (SAT) begin
                    w_q_nxt   = C_MAX;
                    w_sat_nxt = 1'b1;
                end else begin
                    w_q_nxt    = w_sum[WIDTH-1:0] - C_MOD_LO;
                    w_wrap_nxt = 1'b1;
                end
            end else begin
                if (!w_dn_under) begin
                    w_q_nxt = r_q - step;
                end else if (SAT) begin
                    w_q_nxt   = '0;
                    w_sat_nxt = 1'b1;
                end else begin
                    w_q_nxt    = r_q + C_MOD_LO - step;
                    w_wrap_nxt = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            r_q     <= '0;
            r_wrap  <= 1'b0;
            r_sat   <= 1'b0;
            r_lderr <= 1'b0;
        end else begin
            r_q     <= w_q_nxt;
            r_wrap  <= w_wrap_nxt;
            r_sat   <= w_sat_nxt;
            r_lderr <= w_lderr_nxt;
        end
    end

    assign q     = r_q;
    assign wrap  = r_wrap;
    assign sat   = SAT ? r_sat : 1'b0;
    assign lderr = r_lderr;
    // Terminal count: this edge will wrap or saturate; step 0 never does.
    assign tc    = ena & w_step_nz & (upx ? w_dn_under : w_up_over);

endmodule

// File: tb/tb_udcnt_mod.sv
// Bench for udcnt_mod: three instances (mod-200 wrap, mod-200 saturate,
// mod-16 power-of-two wrap) driven in lockstep against an arithmetic model.
module tb_udcnt_mod;

    logic       clk = 1'b0;
    logic       rstx, clr, load, ena, upx;
    logic [7:0] ld8, st8;
    logic [3:0] ld4, st4;

    logic [7:0] q0, q1;
    logic [3:0] q2;
    logic       wr0, wr1, wr2, tc0, tc1, tc2, sa0, sa1, sa2, le0, le1, le2;

    udcnt_mod #(.WIDTH(8), .MODULUS(200), .SAT(1'b0)) u0 (
        .clk(clk), .rstx(rstx), .clr(clr), .load(load), .ld_val(ld8), .ena(ena),
        .upx(upx), .step(st8), .q(q0), .wrap(wr0), .tc(tc0), .sat(sa0), .lderr(le0));
    udcnt_mod #(.WIDTH(8), .MODULUS(200), .SAT(1'b1)) u1 (
        .clk(clk), .rstx(rstx), .clr(clr), .load(load), .ld_val(ld8), .ena(ena),
        .upx(upx), .step(st8), .q(q1), .wrap(wr1), .tc(tc1), .sat(sa1), .lderr(le1));
    udcnt_mod #(.WIDTH(4), .MODULUS(16), .SAT(1'b0)) u2 (
        .clk(clk), .rstx(rstx), .clr(clr), .load(load), .ld_val(ld4), .ena(ena),
        .upx(upx), .step(st4), .q(q2), .wrap(wr2), .tc(tc2), .sat(sa2), .lderr(le2));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int mq[3], mwr[3], msat[3], mle[3];
    int modv[3] = '{200, 200, 16};
    int satv[3] = '{0, 1, 0};
    int tc_pre[3];

    typedef struct {
        bit c; bit l; int ld; bit e; bit u; int st;
        int etc; int eq; int ewr; int ele;
    } vec_t;
    vec_t tbl[15];

    function automatic int act(int k, int f);
        case (k)
            0: case (f) 0: return int'(q0); 1: return int'(wr0); 2: return int'(sa0);
                        3: return int'(le0); default: return int'(tc0); endcase
            1: case (f) 0: return int'(q1); 1: return int'(wr1); 2: return int'(sa1);
                        3: return int'(le1); default: return int'(tc1); endcase
            default: case (f) 0: return int'(q2); 1: return int'(wr2); 2: return int'(sa2);
                        3: return int'(le2); default: return int'(tc2); endcase
        endcase
    endfunction

    task automatic chk(string nm, int a, int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, a, e, $time);
        end
    endtask

    function automatic int exp_tc(int k, bit e, bit u, int st);
        if (!e || st == 0) return 0;
        if (u) return (mq[k] < st) ? 1 : 0;
        return (mq[k] + st >= modv[k]) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k] = 0; mwr[k] = 0; msat[k] = 0; mle[k] = 0;
        end
    endtask

    // One clock edge of the counter rules, in plain integer arithmetic.
    task automatic model_edge(int k, bit c, bit l, int ld, bit e, bit u, int st);
        int s;
        mwr[k] = 0;
        mle[k] = 0;
        if (c) begin
            mq[k] = 0; msat[k] = 0;
        end else if (l) begin
            if (ld < modv[k]) mq[k] = ld;
            else mle[k] = 1;
        end else if (e) begin
            if (!u) begin
                s = mq[k] + st;
                if (s < modv[k]) mq[k] = s;
                else if (satv[k] == 0) begin mq[k] = s - modv[k]; mwr[k] = 1; end
                else begin mq[k] = modv[k] - 1; msat[k] = 1; end
            end else begin
                if (mq[k] >= st) mq[k] = mq[k] - st;
                else if (satv[k] == 0) begin mq[k] = mq[k] + modv[k] - st; mwr[k] = 1; end
                else begin mq[k] = 0; msat[k] = 1; end
            end
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("q%0d", k), act(k, 0), mq[k]);
            chk($sformatf("wrap%0d", k), act(k, 1), mwr[k]);
            chk($sformatf("sat%0d", k), act(k, 2), msat[k]);
            chk($sformatf("lderr%0d", k), act(k, 3), mle[k]);
        end
    endtask

    // Drive one cycle: check tc before the edge, registered outputs after it.
    task automatic apply(bit c, bit l, int ld, bit e, bit u, int st, int ld_4, int st_4);
        clr = c; load = l; ld8 = 8'(ld); ena = e; upx = u; st8 = 8'(st);
        ld4 = 4'(ld_4); st4 = 4'(st_4);
        #1;
        for (int k = 0; k < 3; k++) begin
            tc_pre[k] = act(k, 4);
            chk($sformatf("tc%0d", k), tc_pre[k], exp_tc(k, e, u, (k == 2) ? st_4 : st));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++)
            model_edge(k, c, l, (k == 2) ? ld_4 : ld, e, u, (k == 2) ? st_4 : st);
        #1;
        check_outputs();
    endtask

    initial begin
        tbl[0]  = '{1, 0,   0, 0, 0,  0, 0,   0, 0, 0};
        tbl[1]  = '{0, 1, 198, 0, 0,  0, 0, 198, 0, 0};
        tbl[2]  = '{0, 0,   0, 1, 0,  1, 0, 199, 0, 0};
        tbl[3]  = '{0, 0,   0, 1, 0,  1, 1,   0, 1, 0};
        tbl[4]  = '{0, 0,   0, 1, 1,  1, 1, 199, 1, 0};
        tbl[5]  = '{0, 1, 190, 0, 0,  0, 0, 190, 0, 0};
        tbl[6]  = '{0, 0,   0, 1, 0, 15, 1,   5, 1, 0};
        tbl[7]  = '{0, 1,   3, 0, 0,  0, 0,   3, 0, 0};
        tbl[8]  = '{0, 0,   0, 1, 1, 10, 1, 193, 1, 0};
        tbl[9]  = '{0, 1, 200, 0, 0,  0, 0, 193, 0, 1};
        tbl[10] = '{0, 0,   0, 0, 0,  0, 0, 193, 0, 0};
        tbl[11] = '{0, 1, 120, 1, 0,  5, 0, 120, 0, 0};
        tbl[12] = '{1, 1,  50, 1, 0,  1, 0,   0, 0, 0};
        tbl[13] = '{0, 0,   0, 1, 0,  0, 0,   0, 0, 0};
        tbl[14] = '{0, 0,   0, 1, 1,  0, 0,   0, 0, 0};

        rstx = 1'b0; clr = 1'b0; load = 1'b0; ena = 1'b0; upx = 1'b0;
        ld8 = '0; st8 = '0; ld4 = '0; st4 = '0;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rstx = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors on the mod-200 wrap instance.
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].c, tbl[i].l, tbl[i].ld, tbl[i].e, tbl[i].u, tbl[i].st, 0, 0);
            chk($sformatf("tbl%0d_tc", i), tc_pre[0], tbl[i].etc);
            chk($sformatf("tbl%0d_q", i), int'(q0), tbl[i].eq);
            chk($sformatf("tbl%0d_wrap", i), int'(wr0), tbl[i].ewr);
            chk($sformatf("tbl%0d_lderr", i), int'(le0), tbl[i].ele);
        end

        // Saturation corner cases.
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 195, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 10, 0, 0);
        chk("sat_up_tc", tc_pre[1], 1);
        chk("sat_up_q", int'(q1), 199);
        chk("sat_up_flag", int'(sa1), 1);
        chk("sat_up_wrap", int'(wr1), 0);
        apply(0, 0, 0, 1, 1, 199, 0, 0);
        chk("sat_dn199_q", int'(q1), 0);
        chk("sat_dn199_flag", int'(sa1), 1);
        apply(0, 0, 0, 1, 1, 5, 0, 0);
        chk("sat_dn_tc", tc_pre[1], 1);
        chk("sat_dn_q", int'(q1), 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_clr_q", int'(q1), 0);
        chk("sat_clr_flag", int'(sa1), 0);

        // Power-of-two modulus.
        apply(0, 1, 0, 0, 0, 0, 15, 0);
        apply(0, 0, 0, 1, 0, 0, 0, 1);
        chk("p2_wrap_q", int'(q2), 0);
        chk("p2_wrap_flag", int'(wr2), 1);
        apply(0, 1, 0, 0, 0, 0, 10, 0);
        apply(0, 0, 0, 1, 0, 0, 0, 7);
        chk("p2_step7_tc", tc_pre[2], 1);
        chk("p2_step7_q", int'(q2), 1);
        apply(0, 0, 0, 1, 1, 0, 0, 4);
        chk("p2_down_q", int'(q2), 13);

        // Asynchronous reset in the middle of a count.
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (57) apply(0, 0, 0, 1, 0, 1, 0, 1);
        chk("pre_rst_q", int'(q0), 57);
        #3;
        rstx = 1'b0;
        #1;
        model_reset();
        chk("rst_q", int'(q0), 0);
        chk("rst_tc", int'(tc0), 0);
        check_outputs();
        #2;
        rstx = 1'b1;
        apply(0, 0, 0, 1, 0, 1, 0, 1);
        chk("post_rst_q", int'(q0), 1);

        // Randomised traffic against the model.
        repeat (400) begin
            bit c, l, e, u;
            int st, ld;
            c  = ($urandom_range(0, 31) == 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 199))
                                              : int'($urandom_range(0, 20));
            ld = int'($urandom_range(0, 255));
            apply(c, l, ld, e, u, st, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udcnt_mod.md
# udcnt_mod

Parametrised up/down modulo counter, the general-purpose successor to the fixed 8-bit mod-200 up/down counter in the education blocks. It adds:
- a programmable modulus and width;
- a variable step size;
- synchronous clear and load;
- a wrap or saturate mode;
- a registered wrap pulse and a combinational terminal-count output for cascading.

It sits wherever a timebase, address or position counter with a non-power-of-two range is needed.

## Interface
Parameters:
- WIDTH, 8, counter and step width in bits.
- MODULUS, 200, counting range 0..MODULUS-1. Legal range 2 ≤ MODULUS ≤ 2^WIDTH.
- SAT, 0, boundary mode. 0 = wrap modulo MODULUS; 1 = saturate at 0 / MODULUS-1.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rstx  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear to 0, active-high.
- load  in  1  synchronous load of ld_val, active-high.
- ld_val  in  WIDTH  load value.
- ena  in  1  count enable, active-high.
- upx  in  1  direction, active-low up: 0 = count up, 1 = count down.
- step  in  WIDTH  increment per enabled cycle; must be < MODULUS.
- q  out  WIDTH  counter value, registered.
- wrap  out  1  registered one-cycle pulse: the last update crossed the range boundary.
- tc  out  1  combinational terminal count.
- sat  out  1  sticky saturation flag, registered; SAT=1 only, tied 0 when SAT=0.
- lderr  out  1  registered one-cycle pulse: the last load was rejected.

## Operation
- **Priority per edge:** rstx low > clr > load > ena > hold.
- **Reset (rstx = 0):** immediately forces q = 0, wrap = 0, sat = 0, lderr = 0. This holds regardless of clk, including in the middle of a count.
- **clr:** q ← 0, sat ← 0, wrap ← 0, lderr ← 0.
- **load:**
  - If ld_val < MODULUS: q ← ld_val and lderr ← 0.
  - Otherwise: q holds and lderr ← 1.
  - wrap ← 0. sat is unchanged.
- **ena, upx = 0 (up):** compute s = q + step in WIDTH+1 bits.
  - If s < MODULUS: q ← s.
  - If s ≥ MODULUS and SAT = 0: q ← s − MODULUS, wrap ← 1.
  - If s ≥ MODULUS and SAT = 1: q ← MODULUS−1, sat ← 1, wrap ← 0.
- **ena, upx = 1 (down):**
  - If q ≥ step: q ← q − step.
  - If q < step and SAT = 0: q ← q + MODULUS − step, computed in WIDTH+1 bits, and wrap ← 1.
  - If q < step and SAT = 1: q ← 0, sat ← 1.
- **step = 0 with ena:** q holds, wrap ← 0. This is not a boundary event.
- **step ≥ MODULUS:** illegal. The bench does not drive it; the RTL needs no defined result.
- **No action this cycle** (no clr, load or ena): wrap ← 0 and lderr ← 0. q and sat hold.
- **tc:** equals ena & (upx ? (q < step) : (q + step ≥ MODULUS)), with step > 0. It is asserted exactly in a cycle whose edge will wrap or saturate. It is not gated by clr or load.
- **Width rule:** every intermediate sum and difference is WIDTH+1 bits wide. No truncation is allowed before the compare against MODULUS. MODULUS = 2^WIDTH must work; tc then uses the WIDTH+1-bit compare.

## Timing
- **Latency:** q, wrap, sat and lderr change one clock after the qualifying input is sampled.
- **wrap:** high in the same cycle q shows the wrapped value. It is high for exactly one cycle unless the next enabled step wraps again.
- **Zero-latency path:** tc is combinational from q, ena, upx and step. Cascade by driving the next stage's ena from tc of this stage.
- **Reset release:** rstx deassertion is synchronised externally. The first edge after release behaves as a normal edge.
- **Simultaneous controls:** clr together with load and ena results in q = 0. load together with ena means load wins and no step is applied.
- **Back-to-back:** the direction may change every cycle with no bubble cycles.

## Test plan
- **Reset mid-count (defaults):** count up to q = 57, then pulse rstx low between edges → q = 0 and all flags 0 asynchronously. On release, counting resumes from 0.
- **Wrap-around (SAT=0, MODULUS=200):**
  - up, step = 1, from 198: q = 199 then 0 with wrap = 1. tc = 1 while q = 199.
  - down, step = 1, from 0: q = 199 with wrap = 1.
- **Large step (MODULUS=200, SAT=0):**
  - load 190, up, step = 15 → q = 5, wrap = 1.
  - load 3, down, step = 10 → q = 193, wrap = 1.
- **Saturate (SAT=1, MODULUS=200):**
  - load 195, up, step = 10 → q = 199, sat = 1, wrap = 0.
  - down, step = 250 is illegal and skipped; down, step = 199 → q = 0, sat remains 1.
  - clr → q = 0, sat = 0.
- **Load and priority:**
  - load ld_val = 200 → q unchanged, lderr = 1 for one cycle.
  - load 120 with ena = 1 → q = 120.
  - clr, load and ena together → q = 0.
- **Power-of-two modulus (WIDTH=4, MODULUS=16):**
  - up from 15, step = 1 → q = 0, wrap = 1.
  - up from 10, step = 7 → q = 1.
